// File: rtl/video_scanout_if.sv
// video_scanout_if: RAM read port plus video-encoder output bundle.
// master: the scanout engine (drives address, pixels, syncs).
// slave : the RAM/encoder side (returns read data, consumes video).
interface video_scanout_if;
    logic [9:0]  read_ad;
    logic        read_wre;
    logic [17:0] read_data;
    logic [17:0] rgb;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic        frame_start;

    modport master (
        output read_ad, read_wre, rgb, de, hsync, vsync, frame_start,
        input  read_data
    );

    modport slave (
        input  read_ad, read_wre, rgb, de, hsync, vsync, frame_start,
        output read_data
    );
endinterface

// File: rtl/video_scanout.sv
// video_scanout: VGA-style raster generator. Walks a 32x32 cell map held in
// a 1024x18 video RAM and paints every cell as a solid CELL_W x CELL_H block
// of RGB666. All outputs are registered and share a two-clock latency from
// the stage-0 counters.
// Optional feature macro: VIDEO_SCANOUT_BORDER_EN draws a one-pixel frame
// in BORDER_COLOR around the active area.
module video_scanout #(
    parameter int          H_ACTIVE     = 640,
    parameter int          H_FP         = 16,
    parameter int          H_SYNC       = 96,
    parameter int          H_BP         = 48,
    parameter int          V_ACTIVE     = 480,
    parameter int          V_FP         = 10,
    parameter int          V_SYNC       = 2,
    parameter int          V_BP         = 33,
    parameter int          CELL_W       = 20,
    parameter int          CELL_H       = 15,
    parameter logic        SYNC_POL     = 1'b0,
    parameter logic [17:0] BORDER_COLOR = 18'h3FFFF
) (
    input logic             clk,
    input logic             reset,
    video_scanout_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SXW     = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int SYW     = (CELL_H > 1) ? $clog2(CELL_H) : 1;

    localparam logic [HW-1:0]  H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0]  H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0]  H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0]  H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0]  V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0]  V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0]  V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0]  V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SXW-1:0] SX_LAST    = SXW'(CELL_W - 1);
    localparam logic [SYW-1:0] SY_LAST    = SYW'(CELL_H - 1);
    localparam logic [4:0]     CELL_MAX   = 5'd31;

    // stage 0: raster counters and cell indices
    logic [HW-1:0]  h_cnt_p0;
    logic [VW-1:0]  v_cnt_p0;
    logic [SXW-1:0] sub_x_p0;
    logic [SYW-1:0] sub_y_p0;
    logic [4:0]     col_p0;
    logic [4:0]     row_p0;
    logic           h_wrap;
    logic           v_wrap;
    logic           h_act;
    logic           v_act;
    logic           vld_p0;
    logic           hs_p0;
    logic           vs_p0;
    logic           fs_p0;

    // stage 1: flags aligned with the RAM read data
    logic           vld_p1;
    logic           hs_p1;
    logic           vs_p1;
    logic           fs_p1;
    logic [17:0]    pix_p1;

    // stage 2: output pins
    logic [17:0]    rgb_p2;
    logic           de_p2;
    logic           hsync_p2;
    logic           vsync_p2;
    logic           fs_p2;

    // Decode wrap points, active window and sync windows from the counters.
    always_comb begin
        h_wrap = (h_cnt_p0 == H_LAST);
        v_wrap = (v_cnt_p0 == V_LAST);
        h_act  = (h_cnt_p0 < H_ACT_END);
        v_act  = (v_cnt_p0 < V_ACT_END);
        vld_p0 = h_act && v_act;
        hs_p0  = (h_cnt_p0 >= H_SYNC_BEG) && (h_cnt_p0 < H_SYNC_END);
        vs_p0  = (v_cnt_p0 >= V_SYNC_BEG) && (v_cnt_p0 < V_SYNC_END);
        fs_p0  = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
    end

    // Raster counters plus cell sub-counters; cells are tracked by counting
    // pixels/lines within a cell rather than dividing the raster position.
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_cnt_p0 <= '0;
            v_cnt_p0 <= '0;
            sub_x_p0 <= '0;
            col_p0   <= '0;
            sub_y_p0 <= '0;
            row_p0   <= '0;
        end else begin
            h_cnt_p0 <= h_wrap ? '0 : h_cnt_p0 + 1'b1;
            if (h_wrap) begin
                v_cnt_p0 <= v_wrap ? '0 : v_cnt_p0 + 1'b1;
            end

            if (h_wrap) begin
                sub_x_p0 <= '0;
                col_p0   <= '0;
            end else if (h_act) begin
                if (sub_x_p0 == SX_LAST) begin
                    sub_x_p0 <= '0;
                    if (col_p0 != CELL_MAX) begin
                        col_p0 <= col_p0 + 1'b1;
                    end
                end else begin
                    sub_x_p0 <= sub_x_p0 + 1'b1;
                end
            end

            if (h_wrap) begin
                if (v_wrap) begin
                    sub_y_p0 <= '0;
                    row_p0   <= '0;
                end else if (v_act) begin
                    if (sub_y_p0 == SY_LAST) begin
                        sub_y_p0 <= '0;
                        if (row_p0 != CELL_MAX) begin
                            row_p0 <= row_p0 + 1'b1;
                        end
                    end else begin
                        sub_y_p0 <= sub_y_p0 + 1'b1;
                    end
                end
            end
        end
    end

    // The RAM registers this address itself, so it leaves straight from stage 0.
    assign bus.read_ad  = {row_p0, col_p0};
    assign bus.read_wre = 1'b0;

    // stage 0 -> stage 1
    // Delay the timing flags one clock so they line up with read_data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
            vs_p1  <= 1'b0;
            fs_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            fs_p1  <= fs_p0;
        end
    end

`ifdef VIDEO_SCANOUT_BORDER_EN
    localparam logic [HW-1:0] H_EDGE = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_EDGE = VW'(V_ACTIVE - 1);

    logic bdr_p0;
    logic bdr_p1;

    assign bdr_p0 = vld_p0 && ((h_cnt_p0 == '0) || (h_cnt_p0 == H_EDGE) ||
                               (v_cnt_p0 == '0) || (v_cnt_p0 == V_EDGE));

    // Carry the border flag alongside the other stage-1 flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bdr_p1 <= 1'b0;
        end else begin
            bdr_p1 <= bdr_p0;
        end
    end

    assign pix_p1 = bdr_p1 ? BORDER_COLOR : bus.read_data;
`else
    // Border colour has no consumer in this build.
    logic unused_border;
    assign unused_border = ^BORDER_COLOR;
    assign pix_p1        = bus.read_data;
`endif

    // stage 1 -> stage 2
    // Register pins: blank rgb outside active video and apply sync polarity.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb_p2   <= '0;
            de_p2    <= 1'b0;
            hsync_p2 <= ~SYNC_POL;
            vsync_p2 <= ~SYNC_POL;
            fs_p2    <= 1'b0;
        end else begin
            rgb_p2   <= vld_p1 ? pix_p1 : '0;
            de_p2    <= vld_p1;
            hsync_p2 <= hs_p1 ? SYNC_POL : ~SYNC_POL;
            vsync_p2 <= vs_p1 ? SYNC_POL : ~SYNC_POL;
            fs_p2    <= fs_p1;
        end
    end

    assign bus.rgb         = rgb_p2;
    assign bus.de          = de_p2;
    assign bus.hsync       = hsync_p2;
    assign bus.vsync       = vsync_p2;
    assign bus.frame_start = fs_p2;

endmodule

// File: doc/video_scanout.md
Name: video_scanout

Overview:
- Downstream consumer of the 1024x18 dual-port video RAM.
- Generates VGA-style timing and drives the RAM read-port address.
- Expands each 18-bit RAM word into one solid-colour cell: 32x32 cells, each CELL_W x CELL_H pixels, RGB666.
- Outputs registered pixel colour plus hsync/vsync/de to the video encoder.

Parameters:
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, hsync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
CELL_W, 20, pixels per cell horizontally (H_ACTIVE/32)
CELL_H, 15, lines per cell vertically (V_ACTIVE/32)
SYNC_POL, 0, sync active level (0 = active-low)
BORDER_COLOR, 18'h3FFFF, colour used by the optional border feature

Ports:
clk  in  1  pixel clock; also the RAM read-port clock
reset  in  1  synchronous, active-low reset
read_ad  out  10  RAM read address {row[4:0], col[4:0]}
read_wre  out  1  RAM read-port write enable; constant 0
read_data  in  18  RAM read data, valid one cycle after read_ad is sampled
rgb  out  18  pixel {R[5:0],G[5:0],B[5:0]}; 0 when de=0
de  out  1  active-video enable
hsync  out  1  horizontal sync, level per SYNC_POL
vsync  out  1  vertical sync, level per SYNC_POL
frame_start  out  1  one-cycle pulse coincident with output pixel (0,0)

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-low. While reset=0 at a clk edge:
  - counters, cell indices and delay pipes are cleared;
  - rgb=0, de=0, frame_start=0, read_ad=0;
  - hsync and vsync are held at their inactive level (~SYNC_POL).
- Reset mid-frame: the next cycle after release restarts at h=0, v=0. No partial-line output.
- Stage 0 counters:
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and counts 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
  - Both wrap to 0; a simultaneous h and v wrap starts a new frame.
- Cell indexing, no division, using sub-counters:
  - sub_x/col advance each clock while h_cnt<H_ACTIVE. sub_x wraps at CELL_W-1 and then col increments.
  - col and sub_x clear to 0 at h_cnt wrap.
  - sub_y/row advance at each h_cnt wrap while v_cnt<V_ACTIVE. sub_y wraps at CELL_H-1 and then row increments.
  - row and sub_y clear to 0 at frame wrap.
  - col and row saturate at 31 and never exceed 31.
- Address:
  - read_ad = {row,col} is driven combinationally from the stage-0 registers in cycle N.
  - The RAM registers it at the end of cycle N; read_data is valid in cycle N+1.
- Output stage, registered at the end of cycle N+1, visible in cycle N+2:
  - de = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE) from cycle N;
  - rgb = de ? read_data : 0;
  - hsync active while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC;
  - vsync active likewise over the V_SYNC line window.
- Alignment: de, hsync and vsync pass through an internal 1-stage pipe so all outputs share the 2-cycle latency. Total latency from counter to pins is exactly 2 clocks.
- frame_start: asserted in the cycle where the output corresponds to h_cnt=0, v_cnt=0.
- Blanking: read_ad continues to be driven with the held value. rgb is forced to 0 regardless of read_data.

Optional Feature:
VIDEO_SCANOUT_BORDER_EN
- Defined: for output pixels with de=1 and (h_cnt==0 or h_cnt==H_ACTIVE-1 or v_cnt==0 or v_cnt==V_ACTIVE-1), rgb = BORDER_COLOR instead of read_data. The border flag is pipelined to stay 2-cycle aligned.
- Undefined: border logic is absent; rgb is always read_data during de.

Test Plan:
- Reset: hold reset=0 for 5 clocks, then release.
  - While held: rgb=0, de=0, hsync=vsync=1, read_ad=0.
  - 2 clocks after release: frame_start=1, de=1.
- Model RAM returns read_data = {8'h0, read_ad}.
  - Output pixel x=0..19 on line 0: rgb=18'h00000.
  - x=20..39: rgb=18'h00001.
  - Line 15, x=0: rgb=18'h00020.
- Line timing:
  - de high exactly 640 clocks per line.
  - hsync low for 96 clocks starting 656 clocks after de rises.
  - Line period 800 clocks.
- Frame timing:
  - 480 de-active lines.
  - vsync low for 2 lines (1600 clocks) starting at line 490.
  - frame_start pulses every 420000 clocks.
- Reset mid-frame: assert reset=0 at line 200, x=300 for 1 clock.
  - Outputs return to reset values.
  - The next frame_start follows release by exactly 2 clocks.
- With VIDEO_SCANOUT_BORDER_EN and RAM data 18'h00000:
  - line 0, line 479, x=0 and x=639 give rgb=18'h3FFFF;
  - pixel (1,1) gives rgb=0.
